// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the F-D-E-M-W pipeline.
// It resolves load-use hazards against E and redirects on a jump retiring
// from M. It freezes the front of the pipe while M waits on data memory,
// aborting after MEM_TIMEOUT cycles in MEM_WAIT. A debug port can halt the
// pipe and single-step it. A saturating counter records front-end stalls.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,  // MEM_WAIT cycles before abort, >= 2
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       d_rs1_ind,
  input  logic [4:0]       d_rs2_ind,
  input  logic             d_rs1_use,
  input  logic             d_rs2_use,
  input  logic [4:0]       e_rd_ind,
  input  logic             e_mem_read,
  input  logic             m_jmp_take,
  input  logic             m_req,
  input  logic             m_ack,
  input  logic             dbg_halt_req,
  input  logic             dbg_step,
  output logic             f_en,
  output logic             d_en,
  output logic             e_en,
  output logic             m_en,
  output logic             w_en,
  output logic             d_flush,
  output logic             e_flush,
  output logic             m_flush,
  output logic             w_flush,
  output logic             pc_load,
  output logic             dbg_halted,
  output logic             mem_abort,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned TMR_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_HALT     = 2'd2
  } state_e;

  // What the pipe does this cycle; the enable/flush pattern follows from it.
  typedef enum logic [2:0] {
    A_ADVANCE,   // redirect, load-use bubble, or plain advance
    A_MEM_HOLD,  // freeze F..M, drain W with a bubble
    A_FREEZE,    // everything held, no bubbles (halt)
    A_ABORT,     // drop the faulting access, resume
    A_RESET      // all stages cleared
  } action_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             mem_abort_q;
  action_e          act;

  logic mem_stall;
  logic mem_done;
  logic load_use;

  assign mem_stall = m_req & ~m_ack;
  assign mem_done  = m_req & m_ack;   // an ack with no request is ignored
  assign load_use  = e_mem_read && (e_rd_ind != 5'd0) &&
                     ((d_rs1_use && (d_rs1_ind == e_rd_ind)) ||
                      (d_rs2_use && (d_rs2_ind == e_rd_ind)));

  // Select this cycle's action and the next state/timer.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned and infers a latch.
    state_d = state_q;
    timer_d = timer_q;
    act     = A_ADVANCE;
    unique case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          act     = A_MEM_HOLD;
          state_d = S_MEM_WAIT;
          timer_d = '0;
        end else if (m_jmp_take || load_use) begin
          act = A_ADVANCE;
        end else if (dbg_halt_req) begin
          act     = A_FREEZE;
          state_d = S_HALT;
        end
      end
      S_MEM_WAIT: begin
        if (mem_done) begin
          act     = A_ADVANCE;
          state_d = S_RUN;
        end else if (timer_q == TMR_LAST) begin
          act     = A_ABORT;
          state_d = S_RUN;
          timer_d = '0;
        end else begin
          act     = A_MEM_HOLD;
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_HALT: begin
        if (dbg_step) begin
          if (mem_stall) begin
            act     = A_MEM_HOLD;
            state_d = S_MEM_WAIT;
            timer_d = '0;
          end else begin
            act = A_ADVANCE;
          end
        end else begin
          act = A_FREEZE;
          if (!dbg_halt_req) state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
        timer_d = '0;
      end
    endcase
    if (rst) begin
      act     = A_RESET;
      state_d = S_RUN;
      timer_d = '0;
    end
  end

  // Decode the action into stage enables, bubbles and the PC redirect.
  always_comb begin
    {f_en, d_en, e_en, m_en, w_en}     = 5'b11111;
    {d_flush, e_flush, m_flush, w_flush} = 4'b0000;
    pc_load = 1'b0;
    unique case (act)
      A_ADVANCE: begin
        if (m_jmp_take) begin
          pc_load = 1'b1;
          {d_flush, e_flush, m_flush} = 3'b111;
        end else if (load_use) begin
          {f_en, d_en} = 2'b00;
          e_flush      = 1'b1;
        end
      end
      A_MEM_HOLD: begin
        {f_en, d_en, e_en, m_en} = 4'b0000;
        w_flush = 1'b1;
      end
      A_FREEZE: begin
        {f_en, d_en, e_en, m_en, w_en} = 5'b00000;
      end
      A_ABORT: begin
        w_flush = 1'b1;
      end
      A_RESET: begin
        {f_en, d_en, e_en, m_en, w_en}     = 5'b00000;
        {d_flush, e_flush, m_flush, w_flush} = 4'b1111;
      end
      default: ;
    endcase
  end

  // State, timeout timer, abort pulse and stall counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= S_RUN;
      timer_q     <= '0;
      mem_abort_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      // Armed one cycle early so the pulse lines up with the abort cycle.
      mem_abort_q <= (state_d == S_MEM_WAIT) && (timer_d == TMR_LAST);
      if (!f_en && (state_q != S_HALT) && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // A late ack still completes the access, so it suppresses the armed pulse.
  assign mem_abort  = mem_abort_q & ~mem_done & ~rst;
  assign dbg_halted = (state_q == S_HALT) & ~rst;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// traffic, all compared each cycle against a behavioural model of the
// sequencer's rules.
module tb_pipe_ctrl;

  localparam int TMO     = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam int RUN  = 0;
  localparam int MW   = 1;
  localparam int HALT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    d_rs1_ind, d_rs2_ind, e_rd_ind;
  logic          d_rs1_use, d_rs2_use, e_mem_read;
  logic          m_jmp_take, m_req, m_ack, dbg_halt_req, dbg_step;
  logic          f_en, d_en, e_en, m_en, w_en;
  logic          d_flush, e_flush, m_flush, w_flush;
  logic          pc_load, dbg_halted, mem_abort;
  logic [CW-1:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  int m_st  = RUN;
  int m_tmr = 0;
  int m_cnt = 0;
  int nx_st, nx_tmr, nx_cnt;
  bit saw_abort;

  pipe_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .d_rs1_ind(d_rs1_ind), .d_rs2_ind(d_rs2_ind),
    .d_rs1_use(d_rs1_use), .d_rs2_use(d_rs2_use),
    .e_rd_ind(e_rd_ind), .e_mem_read(e_mem_read),
    .m_jmp_take(m_jmp_take), .m_req(m_req), .m_ack(m_ack),
    .dbg_halt_req(dbg_halt_req), .dbg_step(dbg_step),
    .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en), .w_en(w_en),
    .d_flush(d_flush), .e_flush(e_flush), .m_flush(m_flush), .w_flush(w_flush),
    .pc_load(pc_load), .dbg_halted(dbg_halted), .mem_abort(mem_abort),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    d_rs1_ind = 5'd0; d_rs2_ind = 5'd0; e_rd_ind = 5'd0;
    d_rs1_use = 1'b0; d_rs2_use = 1'b0; e_mem_read = 1'b0;
    m_jmp_take = 1'b0; m_req = 1'b0; m_ack = 1'b0;
    dbg_halt_req = 1'b0; dbg_step = 1'b0;
  endtask

  // Work out what the pipe must do this cycle from the current inputs, then
  // compare every output and compute the model's next state.
  task automatic model_and_check();
    bit         stall_mem, done_mem, hazard, abort_exp, halted_exp;
    logic [4:0] en_exp;   // {f,d,e,m,w}
    logic [3:0] fl_exp;   // {d,e,m,w}
    logic       pc_exp;
    stall_mem = m_req && !m_ack;
    done_mem  = m_req && m_ack;
    hazard    = e_mem_read && (e_rd_ind != 5'd0) &&
                ((d_rs1_use && d_rs1_ind == e_rd_ind) || (d_rs2_use && d_rs2_ind == e_rd_ind));
    nx_st = m_st; nx_tmr = m_tmr; abort_exp = 1'b0;
    // Default: the pipe advances (redirect / bubble / nothing).
    en_exp = 5'b11111; fl_exp = 4'b0000; pc_exp = 1'b0;
    if (m_jmp_take) begin
      fl_exp = 4'b1110; pc_exp = 1'b1;
    end else if (hazard) begin
      en_exp = 5'b00111; fl_exp = 4'b0100;
    end

    if (rst) begin
      en_exp = 5'b00000; fl_exp = 4'b1111; pc_exp = 1'b0;
      nx_st = RUN; nx_tmr = 0;
    end else if ((m_st == RUN && stall_mem) || (m_st == HALT && dbg_step && stall_mem)) begin
      en_exp = 5'b00001; fl_exp = 4'b0001; pc_exp = 1'b0;
      nx_st = MW; nx_tmr = 0;
    end else if (m_st == RUN) begin
      if (!m_jmp_take && !hazard && dbg_halt_req) begin
        en_exp = 5'b00000; fl_exp = 4'b0000;
        nx_st = HALT;
      end
    end else if (m_st == MW) begin
      if (done_mem) begin
        nx_st = RUN;
      end else if (m_tmr == TMO - 1) begin
        en_exp = 5'b11111; fl_exp = 4'b0001; pc_exp = 1'b0;
        abort_exp = 1'b1; nx_st = RUN; nx_tmr = 0;
      end else begin
        en_exp = 5'b00001; fl_exp = 4'b0001; pc_exp = 1'b0;
        nx_tmr = m_tmr + 1;
      end
    end else if (!dbg_step) begin
      en_exp = 5'b00000; fl_exp = 4'b0000; pc_exp = 1'b0;
      if (!dbg_halt_req) nx_st = RUN;
    end

    halted_exp = !rst && (m_st == HALT);
    if (rst) nx_cnt = 0;
    else if (!en_exp[4] && m_st != HALT && m_cnt < CNT_MAX) nx_cnt = m_cnt + 1;
    else nx_cnt = m_cnt;
    if (abort_exp) saw_abort = 1'b1;

    check("en",      32'({f_en, d_en, e_en, m_en, w_en}), 32'(en_exp));
    check("flush",   32'({d_flush, e_flush, m_flush, w_flush}), 32'(fl_exp));
    check("pc_load", 32'(pc_load), 32'(pc_exp));
    check("halted",  32'(dbg_halted), 32'(halted_exp));
    check("abort",   32'(mem_abort), 32'(abort_exp));
    check("cnt",     32'(stall_cnt), 32'(m_cnt));
  endtask

  // Inputs are set just after a rising edge; outputs sampled mid-phase.
  task automatic run_cycle();
    #2;
    model_and_check();
    @(posedge clk);
    #1;
    m_st = nx_st; m_tmr = nx_tmr; m_cnt = nx_cnt;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset cycle fully checked from here on.
    do_reset();

    // Load-use hazard: one bubble, counter 0 -> 1.
    e_mem_read = 1'b1; e_rd_ind = 5'd5; d_rs1_use = 1'b1; d_rs1_ind = 5'd5;
    run_cycle();
    check("lu_cnt", 32'(stall_cnt), 32'd1);
    // Same with rd = x0: no hazard.
    e_rd_ind = 5'd0; d_rs1_ind = 5'd0;
    run_cycle();
    check("lu_x0_cnt", 32'(stall_cnt), 32'd1);
    idle_inputs();

    // Redirect in RUN.
    m_jmp_take = 1'b1;
    run_cycle();
    m_jmp_take = 1'b0;
    check("jmp_cnt", 32'(stall_cnt), 32'd1);

    // Memory wait: three stalled cycles then ack.
    do_reset();
    m_req = 1'b1;
    repeat (3) run_cycle();
    m_ack = 1'b1;
    run_cycle();
    idle_inputs();
    check("mw_cnt", 32'(stall_cnt), 32'd3);
    run_cycle();

    // Timeout: request never acknowledged.
    do_reset();
    saw_abort = 1'b0;
    m_req = 1'b1;
    repeat (5) run_cycle();
    check("abort_seen", 32'(saw_abort), 32'd1);
    idle_inputs();
    run_cycle();

    // Debug halt during a memory stall waits for the ack.
    do_reset();
    m_req = 1'b1; dbg_halt_req = 1'b1;
    repeat (2) run_cycle();
    m_ack = 1'b1;
    run_cycle();
    m_req = 1'b0; m_ack = 1'b0;
    repeat (2) run_cycle();
    check("halted_now", 32'(dbg_halted), 32'd1);
    dbg_step = 1'b1;
    run_cycle();
    dbg_step = 1'b0;
    run_cycle();
    dbg_halt_req = 1'b0;
    run_cycle();
    check("resumed", 32'(dbg_halted), 32'd0);
    run_cycle();

    // Jump held behind a memory stall, redirects on ack.
    m_req = 1'b1; m_jmp_take = 1'b1;
    repeat (2) run_cycle();
    m_ack = 1'b1;
    run_cycle();
    idle_inputs();
    run_cycle();

    // Counter saturation.
    do_reset();
    e_mem_read = 1'b1; e_rd_ind = 5'd7; d_rs2_use = 1'b1; d_rs2_ind = 5'd7;
    repeat (20) run_cycle();
    check("sat_cnt", 32'(stall_cnt), 32'(CNT_MAX));
    idle_inputs();

    // Reset in the middle of MEM_WAIT, then a full-length wait again.
    m_req = 1'b1;
    repeat (2) run_cycle();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    saw_abort = 1'b0;
    repeat (5) run_cycle();
    check("post_rst_abort", 32'(saw_abort), 32'd1);
    idle_inputs();
    run_cycle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(99) < 2);
      d_rs1_ind  = 5'($urandom_range(3));
      d_rs2_ind  = 5'($urandom_range(3));
      e_rd_ind   = 5'($urandom_range(3));
      d_rs1_use  = 1'($urandom_range(1));
      d_rs2_use  = 1'($urandom_range(1));
      e_mem_read = ($urandom_range(99) < 40);
      m_jmp_take = ($urandom_range(99) < 15);
      if (m_st == MW) m_req = ($urandom_range(99) < 95);
      else            m_req = ($urandom_range(99) < 25);
      m_ack      = ($urandom_range(99) < 30);
      if ($urandom_range(99) < 10) dbg_halt_req = ~dbg_halt_req;
      dbg_step   = ($urandom_range(99) < 20);
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush sequencer for the five-stage pipeline (F, D, E, M, W). It drives the en/flush inputs of the d_register/d_ff banks between stages. It resolves load-use hazards against the execute stage, redirects on a taken jump/branch, and freezes the pipe while the memory stage waits for a data-memory handshake, with a timeout. It also provides a debug halt/single-step port and a saturating stall counter.

Parameters:
MEM_TIMEOUT, 16, MEM_WAIT cycles without m_ack before abort (>=2)
CNT_W, 32, width of stall_cnt

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
d_rs1_ind  in  5  rs1 index of instruction in D
d_rs2_ind  in  5  rs2 index of instruction in D
d_rs1_use  in  1  D instruction reads rs1
d_rs2_use  in  1  D instruction reads rs2
e_rd_ind  in  5  rd index of instruction in E
e_mem_read  in  1  E instruction is a load
m_jmp_take  in  1  registered jmp_take of instruction now in M
m_req  in  1  M stage has a data-memory access outstanding
m_ack  in  1  data memory completes access this cycle
dbg_halt_req  in  1  level request to halt
dbg_step  in  1  pulse: advance one cycle while halted
f_en, d_en, e_en, m_en, w_en  out  1 each  load enable of PC, F/D, D/E, E/M, M/W registers
d_flush, e_flush, m_flush, w_flush  out  1 each  bubble insert into F/D, D/E, E/M, M/W
pc_load  out  1  PC takes jmp_addr this cycle
dbg_halted  out  1  FSM in HALT
mem_abort  out  1  one-cycle pulse on memory timeout
stall_cnt  out  CNT_W  cycles with f_en=0 outside HALT, saturating

Behaviour:
- States: RUN, MEM_WAIT, HALT. Enables, flushes and pc_load are Mealy outputs of (state, inputs). The timer and stall_cnt are registered.
- rst=1: state<=RUN, timer<=0, stall_cnt<=0, mem_abort<=0. While rst=1, all en=0 and all flush=1, pc_load=0, dbg_halted=0.
- Default (no event): all en=1, all flush=0, pc_load=0.
- mem_stall = m_req & ~m_ack.
- load_use = e_mem_read & e_rd_ind!=0 & ((d_rs1_use & d_rs1_ind==e_rd_ind) | (d_rs2_use & d_rs2_ind==e_rd_ind)).
- RUN priority, highest first:
  1. mem_stall: f/d/e/m_en=0, w_flush=1, next MEM_WAIT, timer<=0.
  2. m_jmp_take: pc_load=1, d_flush=e_flush=m_flush=1, all en=1. The jump retires to W.
  3. load_use: f_en=d_en=0, e_flush=1. This gives exactly one bubble; the hazard clears next cycle because the load has moved to M.
  4. dbg_halt_req: all en=0, no flush, next HALT. Halt is only accepted when 1–3 are all false, so memory drains and redirects complete first.
- MEM_WAIT:
  - m_ack=1: outputs evaluated as RUN items 2–3 (advance), next RUN.
  - Else if timer==MEM_TIMEOUT-1: mem_abort<=1 for one cycle, all en=1, w_flush=1 (faulting access dropped), next RUN.
  - Else: hold as RUN item 1, timer++.
  - dbg_halt_req is ignored in MEM_WAIT.
- HALT:
  - dbg_halted=1, all en=0, flush=0.
  - dbg_step=1: outputs as RUN items 2–3 for that cycle and stay in HALT. If mem_stall, the step is consumed: outputs as RUN item 1 and next MEM_WAIT.
  - dbg_halt_req=0 and no step: next RUN.
- m_ack without m_req is ignored. Simultaneous mem_stall and m_jmp_take: mem_stall wins; the jump is held in M and redirects on the ack cycle.
- stall_cnt increments on any cycle with f_en=0 and state!=HALT and rst=0, and saturates at all-ones.
- Reset asserted mid-MEM_WAIT or HALT returns to RUN next cycle. Outstanding memory state is abandoned.

Test Plan:
- Load-use: e_mem_read=1, e_rd_ind=5, d_rs1_use=1, d_rs1_ind=5 for one cycle -> f_en=d_en=0, e_flush=1 that cycle, stall_cnt 0->1. Same stimulus with e_rd_ind=0 -> no stall.
- Redirect: m_jmp_take=1 in RUN -> same cycle pc_load=1, d/e/m_flush=1, w_en=1, stall_cnt unchanged.
- Memory wait: m_req=1, m_ack=0 for 3 cycles then m_ack=1 -> f..m_en=0 and w_flush=1 for 3 cycles, all en=1 on ack cycle, state RUN after, stall_cnt=3.
- Timeout, MEM_TIMEOUT=4: m_req=1, m_ack never -> mem_abort pulses on the 5th stalled cycle (entry + 4 in MEM_WAIT), w_flush=1 with all en=1 that cycle, then RUN.
- Debug: dbg_halt_req=1 during a mem stall -> no halt until ack. After halt, dbg_halted=1 and all en=0; dbg_step pulse -> one cycle of all en=1; deassert req -> RUN.
- Priority and saturation: mem_stall with m_jmp_take -> pc_load=0 until the ack cycle. With CNT_W=4, 20 stall cycles -> stall_cnt=15. rst mid-MEM_WAIT -> all flush=1, then RUN with timer=0.
